dfi_phy_resp: RTL and testbench

- PHY-side DFI responder, the slave end of the DFI bus driven by the controller's DFI mux.
- Answers the init handshake, captures write data after the write latency, and returns it as read data after the read latency, in loopback order.
- Used as a PHY stand-in for FPGA bring-up and controller regression, so the full controller runs without a real PHY.

---
 rtl/dfi_phy_resp_pkg.sv | 27 ++
 rtl/dfi_phy_resp_if.sv | 25 ++
 rtl/dfi_resp_fifo.sv | 50 +++++
 rtl/dfi_phy_resp.sv | 133 +++++++++++++
 tb/tb_dfi_phy_resp.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dfi_phy_resp_pkg.sv
// Shared types and helpers for the DFI PHY responder: init FSM encoding,
// default FIFO geometry and the byte-mask helper.
package dfi_phy_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } init_st_e;

  localparam int DEF_DEPTH  = 16;
  localparam int PTR_W      = $clog2(DEF_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_MASK_W = MAX_DATA_W / 8;

  // Callers zero-extend into the widest supported bus and truncate the result.
  function automatic logic [MAX_DATA_W-1:0] mask_apply(input logic [MAX_DATA_W-1:0] d,
                                                       input logic [MAX_MASK_W-1:0] m);
    logic [MAX_DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < MAX_MASK_W; i++)
      if (m[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/dfi_phy_resp_if.sv
// DFI init/write/read signal bundle between the controller mux (master)
// and the PHY responder (slave).
interface dfi_phy_resp_if #(
  parameter int DATA_W = 64,
  parameter int MASK_W = DATA_W / 8
);
  logic              dfi_init_start;
  logic              dfi_init_complete;
  logic              dfi_wrdata_en;
  logic [DATA_W-1:0] dfi_wrdata;
  logic [MASK_W-1:0] dfi_wrdata_mask;
  logic              dfi_rddata_en;
  logic [DATA_W-1:0] dfi_rddata;
  logic              dfi_rddata_valid;

  modport master (
    output dfi_init_start, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
    input  dfi_init_complete, dfi_rddata, dfi_rddata_valid
  );

  modport slave (
    input  dfi_init_start, dfi_wrdata_en, dfi_wrdata, dfi_wrdata_mask, dfi_rddata_en,
    output dfi_init_complete, dfi_rddata, dfi_rddata_valid
  );
endinterface

// File: rtl/dfi_resp_fifo.sv
// Loopback FIFO: pop reads pre-cycle contents, so a pop on full frees the slot
// for a same-cycle push and a pop on empty underflows while the push lands.
module dfi_resp_fifo
  import dfi_phy_resp_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              udf
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              push_ok, pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign ovf     = push & full & ~pop;
  assign udf     = pop & empty;
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= wdata;

endmodule

// File: rtl/dfi_phy_resp.sv
// PHY stand-in: init handshake, write capture after the write latency and
// loopback read return. DFI_PHY_RESP_MASK_EN enables byte-mask zeroing on store.
module dfi_phy_resp
  import dfi_phy_resp_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int MASK_W       = DATA_W / 8,
  parameter int T_INIT       = 16,
  parameter int T_PHY_WRDATA = 1,
  parameter int T_RDDATA_EN  = 4,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  dfi_phy_resp_if.slave  dfi,
  output logic           err_underflow,
  output logic           err_overflow,
  output logic           err_early
);
  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
  localparam logic [1:0] S_DONE = 2'(ST_DONE);
  localparam int         CW     = $clog2(T_INIT + 1);
  localparam logic [CW-1:0] CNT_LD = CW'(T_INIT - 1);
  localparam int         WR_ST  = T_PHY_WRDATA;
  // The output register supplies the last read stage.
  localparam int         RD_ST  = T_RDDATA_EN - 1;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              init_done;
  logic              wr_go, rd_go, push, pop;
  logic              full, empty, ovf, udf;
  logic [DATA_W-1:0] push_data, head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (dfi.dfi_init_start) begin
          state <= S_WAIT;
          cnt   <= CNT_LD;
        end
        S_WAIT: if (!dfi.dfi_init_start) begin
          state <= S_IDLE;
          cnt   <= CNT_LD;
        end else if (cnt == '0) begin
          state     <= S_DONE;
          init_done <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_DONE:  init_done <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dfi.dfi_init_complete = init_done;
  assign wr_go = dfi.dfi_wrdata_en & init_done;
  assign rd_go = dfi.dfi_rddata_en & init_done;

  generate
    if (WR_ST == 0) begin : g_wr_direct
      assign push = wr_go;
    end else begin : g_wr_pipe
      logic [WR_ST-1:0] vld_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else begin
          vld_pipe[0] <= wr_go;
          for (int i = 1; i < WR_ST; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end
      assign push = vld_pipe[WR_ST-1];
    end

    if (RD_ST == 0) begin : g_rd_direct
      assign pop = rd_go;
    end else begin : g_rd_pipe
      logic [RD_ST-1:0] vld_pipe;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else begin
          vld_pipe[0] <= rd_go;
          for (int i = 1; i < RD_ST; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end
      assign pop = vld_pipe[RD_ST-1];
    end
  endgenerate

`ifdef DFI_PHY_RESP_MASK_EN
  assign push_data = DATA_W'(mask_apply(MAX_DATA_W'(dfi.dfi_wrdata), MAX_MASK_W'(dfi.dfi_wrdata_mask)));
`else
  logic unused_mask;
  assign unused_mask = ^dfi.dfi_wrdata_mask;
  assign push_data   = dfi.dfi_wrdata;
`endif

  dfi_resp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .udf   (udf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dfi.dfi_rddata       <= '0;
      dfi.dfi_rddata_valid <= 1'b0;
      err_underflow        <= 1'b0;
      err_overflow         <= 1'b0;
      err_early            <= 1'b0;
    end else begin
      dfi.dfi_rddata_valid <= pop;
      if (pop) dfi.dfi_rddata <= head;
      err_underflow <= err_underflow | udf;
      err_overflow  <= err_overflow | ovf;
      err_early     <= err_early | ((dfi.dfi_wrdata_en | dfi.dfi_rddata_en) & ~init_done);
    end
  end

endmodule

// File: tb/tb_dfi_phy_resp.sv
// Scoreboard bench for dfi_phy_resp: a queue-based loopback model predicts
// every read return; a negedge monitor compares whenever rddata_valid is high.
module tb_dfi_phy_resp;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;
  localparam int T_INIT = 16;
  localparam int T_WR   = 1;
  localparam int T_RD   = 4;
  localparam int DEPTH  = 16;
  localparam int NEVER  = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_u, err_o, err_e;

  always #5 clk = ~clk;

  dfi_phy_resp_if #(.DATA_W(DATA_W), .MASK_W(MASK_W)) ifc ();

  dfi_phy_resp #(
    .DATA_W(DATA_W), .MASK_W(MASK_W), .T_INIT(T_INIT),
    .T_PHY_WRDATA(T_WR), .T_RDDATA_EN(T_RD), .DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .dfi           (ifc.slave),
    .err_underflow (err_u),
    .err_overflow  (err_o),
    .err_early     (err_e)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = -1;
  int done_cyc = NEVER;
  bit init_lvl = 1'b0;
  bit mon_en = 1'b0;
  bit m_udf, m_ovf, m_early;
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int wr_due[$];
  int rd_due[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_mask(logic [DATA_W-1:0] d, logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    r = d;
`ifdef DFI_PHY_RESP_MASK_EN
    for (int b = 0; b < MASK_W; b++)
      if (m[b]) r[8*b +: 8] = 8'h00;
`else
    if (m == '1) r = d;
`endif
    return r;
  endfunction

  // Reference: strobes become timed events; at each event time the pop is
  // resolved against a plain queue before any push of the same cycle.
  task automatic model_cycle(bit we, bit re, logic [DATA_W-1:0] d, logic [MASK_W-1:0] m);
    bit done;
    done = (cyc >= done_cyc);
    if (!done) begin
      if (init_lvl) begin
        if (start_cyc < 0) begin
          start_cyc = cyc;
          done_cyc  = cyc + T_INIT + 1;
        end
      end else begin
        start_cyc = -1;
        done_cyc  = NEVER;
      end
    end
    if ((we || re) && !done) m_early = 1'b1;
    if (we && done) wr_due.push_back(cyc + T_WR);
    if (re && done) rd_due.push_back(cyc + T_RD - 1);
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      void'(rd_due.pop_front());
      if (fifo_q.size() == 0) begin
        m_udf = 1'b1;
        exp_q.push_back('0);
      end else exp_q.push_back(fifo_q.pop_front());
    end
    if (wr_due.size() > 0 && wr_due[0] == cyc) begin
      void'(wr_due.pop_front());
      if (fifo_q.size() == DEPTH) m_ovf = 1'b1;
      else fifo_q.push_back(model_mask(d, m));
    end
  endtask

  task automatic drive(bit we, bit re, logic [DATA_W-1:0] d, logic [MASK_W-1:0] m);
    ifc.dfi_init_start  = init_lvl;
    ifc.dfi_wrdata_en   = we;
    ifc.dfi_rddata_en   = re;
    ifc.dfi_wrdata      = d;
    ifc.dfi_wrdata_mask = m;
    model_cycle(we, re, d, m);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, {$urandom, $urandom}, MASK_W'($urandom));
  endtask

  task automatic check_flags(string tag);
    check({tag, "_err_underflow"}, 64'(err_u), 64'(m_udf));
    check({tag, "_err_overflow"},  64'(err_o), 64'(m_ovf));
    check({tag, "_err_early"},     64'(err_e), 64'(m_early));
  endtask

  task automatic apply_reset(bit do_check);
    rst = 1'b1;
    fifo_q.delete(); exp_q.delete(); wr_due.delete(); rd_due.delete();
    m_udf = 0; m_ovf = 0; m_early = 0;
    start_cyc = -1; done_cyc = NEVER; init_lvl = 0;
    ifc.dfi_init_start = 0; ifc.dfi_wrdata_en = 0; ifc.dfi_rddata_en = 0;
    ifc.dfi_wrdata = '0; ifc.dfi_wrdata_mask = '0;
    #1;
    if (do_check) begin
      check("rst_rddata_valid", 64'(ifc.dfi_rddata_valid), 64'd0);
      check("rst_rddata", ifc.dfi_rddata, 64'd0);
      check("rst_init_complete", 64'(ifc.dfi_init_complete), 64'd0);
      check_flags("rst");
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      check("init_complete", 64'(ifc.dfi_init_complete), 64'(cyc >= done_cyc));
      if (ifc.dfi_rddata_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got rddata %h with valid, expected no valid (cycle %0d)",
                   ifc.dfi_rddata, cyc);
        end else check("rddata", ifc.dfi_rddata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [DATA_W-1:0] w;
    apply_reset(1'b1);
    mon_en = 1'b1;

    // strobes before init are ignored and flagged
    drive(1'b1, 1'b0, 64'hdead_beef_0000_0001, '0);
    drive(1'b0, 1'b1, '0, '0);
    idle(8);
    check("early_err_early", 64'(err_e), 64'd1);
    check_flags("early");

    // init_start dropped during WAIT
    init_lvl = 1; idle(5);
    init_lvl = 0; idle(25);
    check("init_drop_complete", 64'(ifc.dfi_init_complete), 64'd0);

    // init timing: complete low at s+T_INIT, high at s+T_INIT+1
    init_lvl = 1;
    s = cyc;
    while (cyc < s + T_INIT) idle(1);
    check("init_before", 64'(ifc.dfi_init_complete), 64'd0);
    idle(1);
    check("init_after", 64'(ifc.dfi_init_complete), 64'd1);

    // reset with two reads in flight
    drive(1'b1, 1'b0, 64'haaaa_0000_0000_0001, '0);
    drive(1'b1, 1'b0, 64'haaaa_0000_0000_0002, '0);
    idle(2);
    drive(1'b0, 1'b1, '0, '0);
    drive(1'b0, 1'b1, '0, '0);
    idle(1);
    apply_reset(1'b1);
    idle(12);
    check("post_rst_valid", 64'(ifc.dfi_rddata_valid), 64'd0);
    check_flags("post_rst");

    init_lvl = 1;
    idle(T_INIT + 3);
    check("reinit_complete", 64'(ifc.dfi_init_complete), 64'd1);

    // directed loopback
    for (int k = 1; k <= 4; k++) begin
      w = {8{8'(k * 8'h11)}};
      drive(1'b1, 1'b0, w, '0);
    end
    idle(4);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b1, '0, '0);
    idle(8);
    check("loop_drained", 64'(exp_q.size()), 64'd0);
    check_flags("loop");

    // underflow, sticky
    drive(1'b0, 1'b1, '0, '0);
    idle(8);
    check("udf_set", 64'(err_u), 64'd1);
    idle(5);
    check("udf_sticky", 64'(err_u), 64'd1);

    // overflow: 17 writes, 17 reads
    for (int k = 0; k < 17; k++) drive(1'b1, 1'b0, {$urandom, $urandom}, '0);
    idle(4);
    check("ovf_set", 64'(err_o), 64'd1);
    for (int k = 0; k < 17; k++) drive(1'b0, 1'b1, '0, '0);
    idle(8);
    check_flags("ovf");

    // byte mask
    drive(1'b1, 1'b0, 64'hffff_ffff_ffff_ffff, 8'b0000_0101);
    idle(3);
    drive(1'b0, 1'b1, '0, '0);
    idle(8);

    // random traffic
    repeat (400)
      drive(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 45),
            {$urandom, $urandom}, MASK_W'($urandom));
    idle(12);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check_flags("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
